// File: rtl/ps2_pkg.sv
// Shared scan-code constants and FSM encoding for the PS/2 scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_TAB    = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_DECODE = 2'd2,
    ST_EMIT   = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_ascii_rom.sv
// Set-2 scan code to ASCII lookup; letters honour shift XOR caps, everything else shift only.
module ps2_ascii_rom
  import ps2_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       shift_i,
  input  logic       caps_i,
  output logic [7:0] ascii_o
);

  logic [7:0] lo;
  logic [7:0] hi;
  logic       alpha;

  always_comb begin
    lo    = 8'h00;
    hi    = 8'h00;
    alpha = 1'b0;
    case (code_i)
      8'h1C: begin lo = "a"; alpha = 1'b1; end
      8'h32: begin lo = "b"; alpha = 1'b1; end
      8'h21: begin lo = "c"; alpha = 1'b1; end
      8'h23: begin lo = "d"; alpha = 1'b1; end
      8'h24: begin lo = "e"; alpha = 1'b1; end
      8'h2B: begin lo = "f"; alpha = 1'b1; end
      8'h34: begin lo = "g"; alpha = 1'b1; end
      8'h33: begin lo = "h"; alpha = 1'b1; end
      8'h43: begin lo = "i"; alpha = 1'b1; end
      8'h3B: begin lo = "j"; alpha = 1'b1; end
      8'h42: begin lo = "k"; alpha = 1'b1; end
      8'h4B: begin lo = "l"; alpha = 1'b1; end
      8'h3A: begin lo = "m"; alpha = 1'b1; end
      8'h31: begin lo = "n"; alpha = 1'b1; end
      8'h44: begin lo = "o"; alpha = 1'b1; end
      8'h4D: begin lo = "p"; alpha = 1'b1; end
      8'h15: begin lo = "q"; alpha = 1'b1; end
      8'h2D: begin lo = "r"; alpha = 1'b1; end
      8'h1B: begin lo = "s"; alpha = 1'b1; end
      8'h2C: begin lo = "t"; alpha = 1'b1; end
      8'h3C: begin lo = "u"; alpha = 1'b1; end
      8'h2A: begin lo = "v"; alpha = 1'b1; end
      8'h1D: begin lo = "w"; alpha = 1'b1; end
      8'h22: begin lo = "x"; alpha = 1'b1; end
      8'h35: begin lo = "y"; alpha = 1'b1; end
      8'h1A: begin lo = "z"; alpha = 1'b1; end
      8'h16: begin lo = "1"; hi = "!"; end
      8'h1E: begin lo = "2"; hi = "@"; end
      8'h26: begin lo = "3"; hi = "#"; end
      8'h25: begin lo = "4"; hi = "$"; end
      8'h2E: begin lo = "5"; hi = "%"; end
      8'h36: begin lo = "6"; hi = "^"; end
      8'h3D: begin lo = "7"; hi = "&"; end
      8'h3E: begin lo = "8"; hi = "*"; end
      8'h46: begin lo = "9"; hi = "("; end
      8'h45: begin lo = "0"; hi = ")"; end
      8'h0E: begin lo = 8'h60; hi = "~"; end
      8'h4E: begin lo = "-"; hi = "_"; end
      8'h55: begin lo = "="; hi = "+"; end
      8'h54: begin lo = "["; hi = "{"; end
      8'h5B: begin lo = "]"; hi = "}"; end
      8'h5D: begin lo = "\\"; hi = "|"; end
      8'h4C: begin lo = ";"; hi = ":"; end
      8'h52: begin lo = "'"; hi = "\""; end
      8'h41: begin lo = ","; hi = "<"; end
      8'h49: begin lo = "."; hi = ">"; end
      8'h4A: begin lo = "/"; hi = "?"; end
      SC_ENTER: begin lo = 8'h0D; hi = 8'h0D; end
      SC_BKSP:  begin lo = 8'h08; hi = 8'h08; end
      SC_SPACE: begin lo = 8'h20; hi = 8'h20; end
      SC_TAB:   begin lo = 8'h09; hi = 8'h09; end
      default:  begin lo = 8'h00; hi = 8'h00; end
    endcase
    // Upper-case letter is the lower-case code with bit 5 cleared
    if (alpha) hi = lo & 8'hDF;
    if (alpha) ascii_o = (shift_i ^ caps_i) ? hi : lo;
    else       ascii_o = shift_i ? hi : lo;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops PS/2 FIFO bytes, folds E0/F0 prefixes into key events, tracks modifiers and holds each event until acked.
//  state  | meaning
//  IDLE   | waiting for a FIFO byte; prefix timeout runs here
//  POP    | latch FIFO head, pop strobe low for this cycle
//  DECODE | classify byte: prefix, or form event and update modifiers/count
//  EMIT   | event held valid until ev_ack
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W      = 12,
  parameter bit EMIT_BREAK = 1'b1,
  parameter int PFX_TMO    = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  output logic             kb_next_n,
  output logic             ev_valid,
  input  logic             ev_ack,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic [7:0]       ev_ascii,
  output logic             mod_shift,
  output logic             mod_ctrl,
  output logic             caps_lock,
  output logic             enter_pulse,
  output logic [CNT_W-1:0] key_count
);

  localparam int TMO_W = $clog2(PFX_TMO + 1);

  ps2_state_e       state_q, state_d;
  logic [7:0]       byte_q;
  logic             brk_pend_q, ext_pend_q;
  logic [TMO_W-1:0] tmo_q;
  logic             lshift_q, rshift_q, lctrl_q, rctrl_q;
  logic             caps_q, caps_held_q;
  logic [7:0]       ev_code_q, ev_ascii_q;
  logic             ev_ext_q, ev_break_q;
  logic [CNT_W-1:0] key_count_q;

  logic             is_prefix, is_make;
  logic [7:0]       rom_ascii, ascii_now;

  assign is_prefix = (byte_q == SC_BRK) || (byte_q == SC_EXT);
  assign is_make   = !brk_pend_q;
  assign mod_shift = lshift_q | rshift_q;
  assign mod_ctrl  = lctrl_q | rctrl_q;
  assign ascii_now = (brk_pend_q || ext_pend_q || mod_ctrl) ? 8'h00 : rom_ascii;

  ps2_ascii_rom u_rom (
    .code_i  (byte_q),
    .shift_i (mod_shift),
    .caps_i  (caps_q),
    .ascii_o (rom_ascii)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (kb_ready) state_d = ST_POP;
      ST_POP:    state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_prefix)                      state_d = ST_IDLE;
        else if (brk_pend_q && !EMIT_BREAK) state_d = ST_IDLE;
        else                                state_d = ST_EMIT;
      end
      ST_EMIT:   if (ev_ack) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    kb_next_n   = (state_q != ST_POP);
    ev_valid    = (state_q == ST_EMIT);
    enter_pulse = (state_q == ST_DECODE) && (byte_q == SC_ENTER) && is_make;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q      <= 8'h00;
      brk_pend_q  <= 1'b0;
      ext_pend_q  <= 1'b0;
      tmo_q       <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      ev_code_q   <= 8'h00;
      ev_ascii_q  <= 8'h00;
      ev_ext_q    <= 1'b0;
      ev_break_q  <= 1'b0;
      key_count_q <= '0;
    end else begin
      if (state_q == ST_POP) byte_q <= kb_data;
      if (state_q == ST_DECODE) begin
        if (byte_q == SC_BRK) begin
          brk_pend_q <= 1'b1;
          tmo_q      <= TMO_W'(PFX_TMO);
        end else if (byte_q == SC_EXT) begin
          ext_pend_q <= 1'b1;
          tmo_q      <= TMO_W'(PFX_TMO);
        end else begin
          ev_code_q  <= byte_q;
          ev_ext_q   <= ext_pend_q;
          ev_break_q <= brk_pend_q;
          ev_ascii_q <= ascii_now;
          brk_pend_q <= 1'b0;
          ext_pend_q <= 1'b0;
          if (!ext_pend_q && byte_q == SC_LSHIFT) lshift_q <= is_make;
          if (!ext_pend_q && byte_q == SC_RSHIFT) rshift_q <= is_make;
          if (byte_q == SC_CTRL) begin
            if (ext_pend_q) rctrl_q <= is_make;
            else            lctrl_q <= is_make;
          end
          // Typematic repeats of caps arrive while still held and must not re-toggle
          if (!ext_pend_q && byte_q == SC_CAPS) begin
            if (is_make) begin
              if (!caps_held_q) caps_q <= ~caps_q;
              caps_held_q <= 1'b1;
            end else begin
              caps_held_q <= 1'b0;
            end
          end
          if (is_make && ascii_now != 8'h00) key_count_q <= key_count_q + 1'b1;
        end
      end else if (state_q == ST_IDLE && (brk_pend_q || ext_pend_q) && !kb_ready) begin
        if (tmo_q == '0) begin
          brk_pend_q <= 1'b0;
          ext_pend_q <= 1'b0;
        end else begin
          tmo_q <= tmo_q - TMO_W'(1);
        end
      end
    end
  end

  assign ev_code   = ev_code_q;
  assign ev_ascii  = ev_ascii_q;
  assign ev_ext    = ev_ext_q;
  assign ev_break  = ev_break_q;
  assign caps_lock = caps_q;
  assign key_count = key_count_q;

endmodule
